acsi_cmd_sequencer: RTL and testbench
=====================================

# acsi_cmd_sequencer

Hardware sequencer that services the ACSI command block on behalf of the IO controller. It polls the ACSI status byte for a pending command, captures the 10 command bytes through the `status_sel`/`status_byte` window, and streams them to the IO controller with a valid/ready handshake. It then converts the controller's response, or a timeout, into the `dma_ack`/`dma_nak`/`dma_status` signals that close the ACSI transaction. It sits between the ACSI register block and the IO-controller link.

## Interface
- `TIMEOUT`, default 24'd1_000_000: clock cycles to wait for a response before issuing NAK; 0 disables the timeout.
- `clk` in 1: system clock. One clock domain only.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 8: per-target enable, one bit per ACSI target 0..7.
- `status_sel` out 4: selects the byte presented on `status_byte`.
- `status_byte` in 8: combinational ACSI window. Indices 0..9 are command bytes. Index 10 is {target[7:5], 0000, busy[0]}.
- `dma_ack` out 1: one-cycle pulse; command accepted and completed.
- `dma_nak` out 1: one-cycle pulse; command rejected.
- `dma_status` out 8: completion status. Held until the next ACK.
- `cmd_valid` out 1: a command byte is available.
- `cmd_ready` in 1: the IO controller accepts the byte.
- `cmd_data` out 8: command byte.
- `cmd_last` out 1: marks byte 9.
- `cmd_target` out 3: target of the current command. Stable for the whole packet.
- `rsp_valid` in 1: single-cycle response strobe.
- `rsp_ok` in 1: 1 means ACK, 0 means NAK. Qualified by `rsp_valid`.
- `rsp_status` in 8: status byte to report on ACK.

## Operation
- **States:** IDLE, CAPTURE, CHECK, SEND, WAIT_RSP, ACK, NAK, DRAIN.
- **Sampling rule:** `status_sel` is registered. The byte selected in cycle k is sampled at the clock edge ending cycle k+1, giving one cycle of select-to-sample pipeline.
- **IDLE:** drive `status_sel`=10. When the sampled busy bit is 1, latch target=[7:5], set `status_sel`=0 and go to CAPTURE.
- **CAPTURE:** step `status_sel` 0→9, one per cycle. Store each sample into a 10×8 buffer at index (sel−1). After the byte-9 sample (11 cycles after leaving IDLE), go to CHECK.
- **CHECK:** one cycle.
  - If `enable[target]`=0, go to NAK.
  - Otherwise go to SEND with byte index 0.
- **SEND:** `cmd_valid`=1 and `cmd_data`=buf[idx]. `cmd_last`=(idx==9).
  - On `cmd_valid`&&`cmd_ready`, increment idx.
  - After byte 9 is accepted, clear the timeout counter and go to WAIT_RSP.
  - `cmd_data`, `cmd_last` and `cmd_target` must not change while `cmd_valid`=1 and `cmd_ready`=0.
- **WAIT_RSP:**
  - On `rsp_valid` with `rsp_ok`=1: load `dma_status`←`rsp_status` and go to ACK.
  - On `rsp_valid` with `rsp_ok`=0: go to NAK.
  - Otherwise the 24-bit counter increments. When it reaches `TIMEOUT`−1 (and `TIMEOUT`≠0), go to NAK.
- **ACK / NAK:** pulse the respective strobe for exactly one cycle, then go to DRAIN.
- **DRAIN:** drive `status_sel`=10. Return to IDLE only after two consecutive busy=0 samples. This prevents a stale busy bit from retriggering the sequencer.
- **Ignored input:** `rsp_valid` outside WAIT_RSP is ignored.
- **Response at the timeout edge:** if `rsp_valid` arrives in the same cycle the counter expires, the response wins.
- **NAK and `dma_status`:** NAK leaves `dma_status` unchanged.

## Timing
- **Reset values:** `status_sel`=10, `dma_ack`=0, `dma_nak`=0, `dma_status`=8'h00, `cmd_valid`=0, `cmd_data`=0, `cmd_last`=0, `cmd_target`=0. State=IDLE and the buffer contents are don't-care.
- **Reset mid-operation:** any state returns to IDLE on the next edge. A partially sent packet is abandoned with no `cmd_last`. Strobes are cleared.
- **Busy to first `cmd_valid`:** 13 cycles from the busy=1 sample: 11 capture cycles, plus 1 CHECK, plus 1 to enter SEND.
- **Streaming rate:** one byte per cycle when `cmd_ready` is held high, so 10 cycles for the packet.
- **Response to strobe:** `rsp_valid` at edge n gives `dma_ack` or `dma_nak` high in cycle n+1, for one cycle.
- **Disabled target:** `dma_nak` is asserted 12 cycles after the busy sample, with no `cmd_valid`.

## Structure
- **Shared package `acsi_pkg`:**
  - State enum.
  - `ACSI_STATUS_IDX`=10, `ACSI_CMD_LEN`=10.
  - Bit positions of target and busy within status byte 10.
  - Byte field indices of `cmd_parameter`, shared with the ACSI block.
- **Module split:** a single module with no sub-module. The buffer, sequencing counter and timeout counter are all local.

## Test plan
- **Basic command:** enable=8'h01; status byte 10 = 8'h01 with bytes 0..9 = 8'h08,1..9, `cmd_ready`=1.
  - Expect 10 bytes 08,01..09 with `cmd_target`=0 and `cmd_last` on byte 9.
  - Then `rsp_valid`, `rsp_ok`=1, `rsp_status`=8'h00 → one-cycle `dma_ack`, `dma_status`=00.
- **Disabled target:** status byte 10 = 8'h61 (target 3), enable=8'h01 → `dma_nak` 12 cycles after busy, no `cmd_valid`, `dma_status` unchanged.
- **Backpressure:** toggle `cmd_ready` 0/1 every cycle → `cmd_data` is held while stalled, the sequence is unchanged, and `cmd_last` is accepted exactly once.
- **Timeout:** `TIMEOUT`=16 with no response → `dma_nak` 16 cycles after byte 9 is accepted. An `rsp_valid` in the expiry cycle instead produces ACK.
- **Reset mid-SEND:** assert `reset` after byte 4 → next cycle `cmd_valid`=0, `status_sel`=10. A later busy produces a fresh packet starting at byte 0.
- **Busy held after ACK:** busy stays 1 for 3 cycles after ACK → no second capture, return to IDLE after two busy=0 samples.

Source files
------------

// File: rtl/acsi_pkg.sv
// Shared ACSI definitions: sequencer states, status-window layout and
// command-block field positions used by both the sequencer and the ACSI block.
package acsi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_CHECK,
      ST_SEND,
      ST_WAIT_RSP,
      ST_ACK,
      ST_NAK,
      ST_DRAIN
   } acsi_state_t;

   localparam logic [3:0] ACSI_STATUS_IDX = 4'd10;
   localparam int         ACSI_CMD_LEN    = 10;
   localparam logic [3:0] ACSI_LAST_IDX   = 4'd9;

   // Layout of status byte 10: {target[7:5], 4'b0000, busy[0]}
   localparam int STAT_TGT_MSB  = 7;
   localparam int STAT_TGT_LSB  = 5;
   localparam int STAT_BUSY_BIT = 0;

   // Byte positions inside cmd_parameter
   localparam int CMD_OPCODE_IDX  = 0;
   localparam int CMD_LBA_HI_IDX  = 1;
   localparam int CMD_LBA_MID_IDX = 2;
   localparam int CMD_LBA_LO_IDX  = 3;
   localparam int CMD_LENGTH_IDX  = 4;
   localparam int CMD_CONTROL_IDX = 5;

   function automatic logic [2:0] status_target(input logic [7:0] stat);
      return stat[STAT_TGT_MSB:STAT_TGT_LSB];
   endfunction

   function automatic logic status_busy(input logic [7:0] stat);
      return stat[STAT_BUSY_BIT];
   endfunction

endpackage

// File: rtl/acsi_cmd_sequencer.sv
// Polls the ACSI status window, captures the 10-byte command block, streams it to
// the IO controller and turns the response (or a timeout) into ACK/NAK strobes.
module acsi_cmd_sequencer
   import acsi_pkg::*;
#(
   parameter logic [23:0] TIMEOUT = 24'd1_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] enable,
   output logic [3:0] status_sel,
   input  logic [7:0] status_byte,
   output logic       dma_ack,
   output logic       dma_nak,
   output logic [7:0] dma_status,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic [7:0] cmd_data,
   output logic       cmd_last,
   output logic [2:0] cmd_target,
   input  logic       rsp_valid,
   input  logic       rsp_ok,
   input  logic [7:0] rsp_status
);

   acsi_state_t state, state_nxt;

   logic [7:0]  stat_byte_p0;
   logic [3:0]  stat_sel_p0;
   logic [7:0]  cmd_buf [ACSI_CMD_LEN];
   logic [3:0]  send_idx;
   logic [23:0] to_cnt;
   logic        drain_zero;

   logic samp_status, samp_busy, samp_idle;
   logic byte_acc, last_acc;
   logic timeout_hit;
   logic tgt_enabled;

   // A sample only counts as status when the select that produced it was 10;
   // this keeps a stale command byte from looking like busy after a reset.
   assign samp_status = (stat_sel_p0 == ACSI_STATUS_IDX);
   assign samp_busy   = samp_status &&  status_busy(stat_byte_p0);
   assign samp_idle   = samp_status && !status_busy(stat_byte_p0);
   assign byte_acc    = cmd_valid && cmd_ready;
   assign last_acc    = byte_acc && cmd_last;
   assign timeout_hit = (TIMEOUT != 24'd0) && (to_cnt == TIMEOUT - 24'd1);
   assign tgt_enabled = enable[cmd_target];

   // Stage p0: window sample, one cycle behind the registered select
   always_ff @(posedge clk) begin
      stat_byte_p0 <= status_byte;
      if (state == ST_CAPTURE && status_sel != 4'd0)
         cmd_buf[status_sel - 4'd1] <= stat_byte_p0;
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:     if (samp_busy) state_nxt = ST_CAPTURE;
         ST_CAPTURE:  if (status_sel == ACSI_STATUS_IDX) state_nxt = ST_CHECK;
         ST_CHECK:    state_nxt = tgt_enabled ? ST_SEND : ST_NAK;
         ST_SEND:     if (last_acc) state_nxt = ST_WAIT_RSP;
         ST_WAIT_RSP: begin
            // A response in the expiry cycle takes priority over the timeout
            if (rsp_valid)
               state_nxt = rsp_ok ? ST_ACK : ST_NAK;
            else if (timeout_hit)
               state_nxt = ST_NAK;
         end
         ST_ACK:      state_nxt = ST_DRAIN;
         ST_NAK:      state_nxt = ST_DRAIN;
         ST_DRAIN:    if (samp_idle && drain_zero) state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   // Stage p1: registered outputs and sequencing counters
   always_ff @(posedge clk) begin
      if (reset) begin
         status_sel  <= ACSI_STATUS_IDX;
         stat_sel_p0 <= 4'd0;
         dma_ack     <= 1'b0;
         dma_nak     <= 1'b0;
         dma_status  <= 8'h00;
         cmd_valid   <= 1'b0;
         cmd_data    <= 8'h00;
         cmd_last    <= 1'b0;
         cmd_target  <= 3'd0;
         send_idx    <= 4'd0;
         to_cnt      <= 24'd0;
         drain_zero  <= 1'b0;
      end else begin
         stat_sel_p0 <= status_sel;
         dma_ack     <= (state_nxt == ST_ACK);
         dma_nak     <= (state_nxt == ST_NAK);
         if (state == ST_WAIT_RSP && rsp_valid && rsp_ok)
            dma_status <= rsp_status;

         case (state)
            ST_IDLE: begin
               status_sel <= ACSI_STATUS_IDX;
               if (samp_busy) begin
                  cmd_target <= status_target(stat_byte_p0);
                  status_sel <= 4'd0;
               end
            end
            ST_CAPTURE: begin
               // Select runs 0..9 then parks on 10 while byte 9 is stored
               if (status_sel != ACSI_STATUS_IDX)
                  status_sel <= status_sel + 4'd1;
               send_idx <= 4'd0;
            end
            ST_CHECK: begin
               send_idx <= 4'd0;
            end
            ST_SEND: begin
               if (last_acc) begin
                  cmd_valid <= 1'b0;
                  cmd_last  <= 1'b0;
                  to_cnt    <= 24'd0;
               end else if (!cmd_valid || byte_acc) begin
                  cmd_valid <= 1'b1;
                  cmd_data  <= cmd_buf[send_idx];
                  cmd_last  <= (send_idx == ACSI_LAST_IDX);
                  send_idx  <= send_idx + 4'd1;
               end
            end
            ST_WAIT_RSP: begin
               to_cnt <= to_cnt + 24'd1;
            end
            ST_ACK, ST_NAK: begin
               drain_zero <= 1'b0;
            end
            ST_DRAIN: begin
               status_sel <= ACSI_STATUS_IDX;
               drain_zero <= samp_idle;
            end
            default: begin
               status_sel <= ACSI_STATUS_IDX;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_acsi_cmd_sequencer.sv
// Scoreboard bench for acsi_cmd_sequencer: a behavioural ACSI status window feeds
// commands, expected bytes are queued at issue time and popped on each handshake.
module tb_acsi_cmd_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] enable;
   logic [3:0] status_sel;
   logic [7:0] status_byte;
   logic       dma_ack;
   logic       dma_nak;
   logic [7:0] dma_status;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_data;
   logic       cmd_last;
   logic [2:0] cmd_target;
   logic       rsp_valid;
   logic       rsp_ok;
   logic [7:0] rsp_status;

   logic [7:0] cmd_bytes [10];
   logic [2:0] st_tgt;
   logic       st_busy;
   logic [8:0] exp_q [$];
   logic [2:0] exp_tgt;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   acsi_cmd_sequencer #(.TIMEOUT(24'd16)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .status_sel (status_sel),
      .status_byte(status_byte),
      .dma_ack    (dma_ack),
      .dma_nak    (dma_nak),
      .dma_status (dma_status),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_data   (cmd_data),
      .cmd_last   (cmd_last),
      .cmd_target (cmd_target),
      .rsp_valid  (rsp_valid),
      .rsp_ok     (rsp_ok),
      .rsp_status (rsp_status)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign status_byte = (status_sel == 4'd10) ? {st_tgt, 4'b0000, st_busy} :
                        (status_sel < 4'd10)  ? cmd_bytes[status_sel] : 8'h00;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] tgt, input logic [7:0] b0,
                        input logic [7:0] step, input logic push);
      for (int i = 0; i < 10; i++)
         cmd_bytes[i] = (i == 0) ? b0 : 8'(i) * step;
      if (push) begin
         for (int i = 0; i < 10; i++)
            exp_q.push_back({(i == 9), cmd_bytes[i]});
         exp_tgt = tgt;
      end
      st_tgt  = tgt;
      st_busy = 1'b1;
   endtask

   task automatic wait_capture_start(output int t0);
      int g = 0;
      while (status_sel == 4'd10 && g < 40) begin
         tick();
         g++;
      end
      t0 = cyc;
      n_checks++;
      if (status_sel !== 4'd0) begin
         n_fail++;
         $display("FAIL capture_start: status_sel=%0d required 0", status_sel);
      end
   endtask

   task automatic collect(input int n, input int mode, input int t0, output int t_last);
      int g = 0, got = 0, lastcnt = 0, first_g = 0;
      logic stalled = 1'b0, seen = 1'b0;
      logic [8:0] held = '0;
      logic [8:0] exp;
      while (got < n && g < 300) begin
         cmd_ready = (mode == 0) ? 1'b1 : g[0];
         if (stalled) begin
            n_checks++;
            if (cmd_valid !== 1'b1 || {cmd_last, cmd_data} !== held) begin
               n_fail++;
               $display("FAIL hold: valid=%b last/data=%h required 1/%h", cmd_valid, {cmd_last, cmd_data}, held);
            end
         end
         if (cmd_valid === 1'b1 && !seen) begin
            seen = 1'b1;
            first_g = g;
            if (t0 >= 0) begin
               n_checks++;
               if (cyc - t0 != 13) begin
                  n_fail++;
                  $display("FAIL first_valid_latency: %0d required 13", cyc - t0);
               end
            end
         end
         stalled = 1'b0;
         if (cmd_valid === 1'b1 && cmd_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL extra_byte: got %h required none", cmd_data);
            end else begin
               exp = exp_q.pop_front();
               if ({cmd_last, cmd_data} !== exp) begin
                  n_fail++;
                  $display("FAIL byte%0d: last/data=%h required %h", got, {cmd_last, cmd_data}, exp);
               end
            end
            n_checks++;
            if (cmd_target !== exp_tgt) begin
               n_fail++;
               $display("FAIL target: %0d required %0d", cmd_target, exp_tgt);
            end
            if (cmd_last === 1'b1) lastcnt++;
            got++;
         end else if (cmd_valid === 1'b1) begin
            stalled = 1'b1;
            held = {cmd_last, cmd_data};
         end
         tick();
         g++;
      end
      cmd_ready = 1'b0;
      t_last = cyc;
      n_checks++;
      if (got < n) begin
         n_fail++;
         $display("FAIL stream_timeout: got %0d bytes required %0d", got, n);
      end
      if (n == 10) begin
         n_checks++;
         if (lastcnt != 1) begin
            n_fail++;
            $display("FAIL last_count: %0d required 1", lastcnt);
         end
         if (mode == 0) begin
            n_checks++;
            if (g - first_g != 10) begin
               n_fail++;
               $display("FAIL stream_rate: %0d cycles required 10", g - first_g);
            end
         end
      end
   endtask

   task automatic send_rsp(input logic ok, input logic [7:0] st, input logic [7:0] exp_status);
      rsp_valid  = 1'b1;
      rsp_ok     = ok;
      rsp_status = st;
      tick();
      rsp_valid = 1'b0;
      n_checks++;
      if (dma_ack !== ok || dma_nak !== !ok) begin
         n_fail++;
         $display("FAIL rsp_strobe: ack=%b nak=%b required ack=%b", dma_ack, dma_nak, ok);
      end
      n_checks++;
      if (dma_status !== exp_status) begin
         n_fail++;
         $display("FAIL dma_status: %h required %h", dma_status, exp_status);
      end
      tick();
      n_checks++;
      if (dma_ack !== 1'b0 || dma_nak !== 1'b0) begin
         n_fail++;
         $display("FAIL strobe_width: ack=%b nak=%b required 0/0", dma_ack, dma_nak);
      end
   endtask

   task automatic finish_txn();
      st_busy = 1'b0;
      repeat (6) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) tick();
      n_checks++;
      if (status_sel !== 4'd10 || cmd_target !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_sel_tgt: sel=%0d tgt=%0d required 10/0", status_sel, cmd_target);
      end
      n_checks++;
      if (dma_ack !== 1'b0 || dma_nak !== 1'b0 || dma_status !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_dma: ack=%b nak=%b status=%h required 0/0/00", dma_ack, dma_nak, dma_status);
      end
      n_checks++;
      if (cmd_valid !== 1'b0 || cmd_data !== 8'h00 || cmd_last !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_cmd: valid=%b data=%h last=%b required 0/00/0", cmd_valid, cmd_data, cmd_last);
      end
      reset = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_basic();
      int t0, tl;
      enable = 8'h01;
      issue(3'd0, 8'h08, 8'h01, 1'b1);
      wait_capture_start(t0);
      collect(10, 0, t0, tl);
      send_rsp(1'b1, 8'h00, 8'h00);
      finish_txn();
   endtask

   task automatic test_backpressure();
      int t0, tl;
      enable = 8'h81;
      issue(3'd7, 8'hE1, 8'h11, 1'b1);
      wait_capture_start(t0);
      collect(10, 1, t0, tl);
      send_rsp(1'b1, 8'h5A, 8'h5A);
      finish_txn();
   endtask

   task automatic test_disabled();
      int t0, g;
      logic bad_valid = 1'b0, seen = 1'b0;
      enable = 8'h01;
      issue(3'd3, 8'h12, 8'h11, 1'b0);
      wait_capture_start(t0);
      // Stray response while capturing must be ignored
      rsp_valid = 1'b1; rsp_ok = 1'b1; rsp_status = 8'hFF;
      tick();
      rsp_valid = 1'b0;
      g = 0;
      while (!seen && g < 30) begin
         if (cmd_valid === 1'b1) bad_valid = 1'b1;
         if (dma_nak === 1'b1) seen = 1'b1;
         else begin
            tick();
            g++;
         end
      end
      n_checks++;
      if (!seen || cyc - t0 != 12) begin
         n_fail++;
         $display("FAIL disabled_nak_latency: seen=%b latency=%0d required 12", seen, cyc - t0);
      end
      n_checks++;
      if (bad_valid) begin
         n_fail++;
         $display("FAIL disabled_no_valid: cmd_valid seen 1 required 0");
      end
      n_checks++;
      if (dma_status !== 8'h5A || dma_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL disabled_status: status=%h ack=%b required 5a/0", dma_status, dma_ack);
      end
      tick();
      n_checks++;
      if (dma_nak !== 1'b0) begin
         n_fail++;
         $display("FAIL disabled_nak_width: nak=%b required 0", dma_nak);
      end
      finish_txn();
   endtask

   task automatic test_timeout();
      int t0, tl, g;
      logic seen = 1'b0;
      enable = 8'hFF;
      issue(3'd5, 8'h28, 8'h07, 1'b1);
      wait_capture_start(t0);
      collect(10, 0, t0, tl);
      g = 0;
      while (!seen && g < 40) begin
         tick();
         g++;
         if (dma_nak === 1'b1) seen = 1'b1;
      end
      n_checks++;
      if (!seen || cyc - tl != 16) begin
         n_fail++;
         $display("FAIL timeout_latency: seen=%b latency=%0d required 16", seen, cyc - tl);
      end
      n_checks++;
      if (dma_status !== 8'h5A || dma_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_status: status=%h ack=%b required 5a/0", dma_status, dma_ack);
      end
      finish_txn();
   endtask

   task automatic test_timeout_edge();
      int t0, tl;
      logic early = 1'b0;
      enable = 8'hFF;
      issue(3'd2, 8'h1F, 8'h13, 1'b1);
      wait_capture_start(t0);
      collect(10, 0, t0, tl);
      repeat (15) begin
         tick();
         if (dma_nak === 1'b1 || dma_ack === 1'b1) early = 1'b1;
      end
      n_checks++;
      if (early) begin
         n_fail++;
         $display("FAIL timeout_early: strobe before expiry required none");
      end
      send_rsp(1'b1, 8'hC3, 8'hC3);
      finish_txn();
   endtask

   task automatic test_reset_mid_send();
      int t0, tl;
      enable = 8'hFF;
      issue(3'd1, 8'hA0, 8'h05, 1'b1);
      wait_capture_start(t0);
      collect(5, 0, t0, tl);
      reset   = 1'b1;
      st_busy = 1'b0;
      tick();
      n_checks++;
      if (cmd_valid !== 1'b0 || cmd_last !== 1'b0 || status_sel !== 4'd10) begin
         n_fail++;
         $display("FAIL mid_reset: valid=%b last=%b sel=%0d required 0/0/10", cmd_valid, cmd_last, status_sel);
      end
      reset = 1'b0;
      exp_q.delete();
      repeat (4) tick();
      n_checks++;
      if (status_sel !== 4'd10 || cmd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_idle: sel=%0d valid=%b required 10/0", status_sel, cmd_valid);
      end
      issue(3'd6, 8'h3C, 8'h09, 1'b1);
      wait_capture_start(t0);
      collect(10, 0, t0, tl);
      send_rsp(1'b1, 8'h77, 8'h77);
      finish_txn();
   endtask

   task automatic test_busy_held();
      int t0, tl;
      logic retrig = 1'b0;
      enable = 8'hFF;
      issue(3'd4, 8'h55, 8'h03, 1'b1);
      wait_capture_start(t0);
      collect(10, 0, t0, tl);
      send_rsp(1'b1, 8'h0F, 8'h0F);
      tick();
      // One isolated busy=0 cycle must not release the drain
      st_busy = 1'b0;
      tick();
      st_busy = 1'b1;
      repeat (2) tick();
      st_busy = 1'b0;
      repeat (20) begin
         if (status_sel !== 4'd10 || cmd_valid !== 1'b0) retrig = 1'b1;
         tick();
      end
      n_checks++;
      if (retrig) begin
         n_fail++;
         $display("FAIL busy_held_retrigger: capture or valid seen required none");
      end
      issue(3'd4, 8'h90, 8'h21, 1'b1);
      wait_capture_start(t0);
      collect(10, 0, t0, tl);
      send_rsp(1'b0, 8'hEE, 8'h0F);
      finish_txn();
   endtask

   initial begin
      reset      = 1'b1;
      enable     = 8'h00;
      cmd_ready  = 1'b0;
      rsp_valid  = 1'b0;
      rsp_ok     = 1'b0;
      rsp_status = 8'h00;
      st_busy    = 1'b0;
      st_tgt     = 3'd0;
      exp_tgt    = 3'd0;
      for (int i = 0; i < 10; i++) cmd_bytes[i] = 8'h00;
      repeat (2) tick();
      test_reset();
      test_basic();
      test_backpressure();
      test_disabled();
      test_timeout();
      test_timeout_edge();
      test_reset_mid_send();
      test_busy_held();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
